// File: rtl/divclk_pkg.sv
// Shared definitions for the clock-divide chain: controller states and default widths.
package divclk_pkg;

   localparam int DIVCLK_CNT_W        = 8;
   localparam int DIVCLK_DEFAULT_HALF = 40;

   // IDLE: stopped, RUN: dividing, PEND: new ratio waiting for a boundary,
   // STOP: finishing the current phase before going idle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2,
      ST_STOP = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_half_counter.sv
// Half-period counter: counts clk cycles within one output phase and flags the last one.
module div_half_counter
   import divclk_pkg::*;
#(
   parameter int CNT_W = DIVCLK_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] half,
   output logic [CNT_W-1:0] cnt,
   output logic             boundary
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] half_m1;

   // Last cycle of a phase is cnt == half-1; half is never 0 so this cannot wrap.
   always_comb begin
      half_m1  = half - CNT_W'(1);
      boundary = enable & (cnt_q == half_m1);
   end

   // Next count: held at zero when cleared, restarts at each boundary, otherwise increments.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (boundary) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Run-time controller for the divided clock: ratio handshake, glitch-free start/stop and edge tick.
module div_ratio_ctrl
   import divclk_pkg::*;
#(
   parameter int CNT_W        = DIVCLK_CNT_W,
   parameter int DEFAULT_HALF = DIVCLK_DEFAULT_HALF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             div_out,
   output logic             tick,
   output logic             busy,
   output logic [CNT_W-1:0] cur_half
);

   div_state_e       state_q, state_d;
   logic             div_out_q, div_out_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] cur_half_q, cur_half_d;
   logic [CNT_W-1:0] pend_half_q, pend_half_d;

   logic             xfer;
   logic             pending;
   logic             at_boundary;
   logic             cnt_clear;
   logic [CNT_W-1:0] cfg_half_clamped;
   logic [CNT_W-1:0] cnt_unused;

   // The counter only runs while the divider is active; in IDLE it is pinned at zero.
   assign cnt_clear = (state_q == ST_IDLE);

   div_half_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .enable   (~cnt_clear),
      .half     (cur_half_q),
      .cnt      (cnt_unused),
      .boundary (at_boundary)
   );

   // Handshake and helper terms; a pending ratio is marked by a non-zero pend_half since stored ratios are >= 1.
   always_comb begin
      cfg_ready        = reset & ((state_q == ST_IDLE) | (state_q == ST_RUN));
      xfer             = cfg_valid & cfg_ready;
      pending          = (pend_half_q != '0);
      cfg_half_clamped = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
   end

   // Next-state, ratio and output logic; ratio changes and stops only take effect at phase boundaries.
   always_comb begin
      state_d     = state_q;
      div_out_d   = div_out_q;
      tick_d      = 1'b0;
      cur_half_d  = cur_half_q;
      pend_half_d = pend_half_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               cur_half_d = cfg_half_clamped;
            end
            if (en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (at_boundary) begin
               div_out_d = ~div_out_q;
               tick_d    = 1'b1;
            end
            if (xfer) begin
               pend_half_d = cfg_half_clamped;
               state_d     = ST_PEND;
            end
            if (!en) begin
               state_d = ST_STOP;
            end
         end
         ST_PEND: begin
            if (at_boundary) begin
               cur_half_d  = pend_half_q;
               pend_half_d = '0;
               div_out_d   = ~div_out_q;
               tick_d      = 1'b1;
               state_d     = ST_RUN;
            end
            if (!en) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (en) begin
               if (pending) begin
                  state_d = ST_PEND;
                  if (at_boundary) begin
                     cur_half_d  = pend_half_q;
                     pend_half_d = '0;
                     div_out_d   = ~div_out_q;
                     tick_d      = 1'b1;
                     state_d     = ST_RUN;
                  end
               end else begin
                  state_d = ST_RUN;
                  if (at_boundary) begin
                     div_out_d = ~div_out_q;
                     tick_d    = 1'b1;
                  end
               end
            end else if (at_boundary) begin
               if (div_out_q) begin
                  div_out_d = 1'b0;
                  tick_d    = 1'b1;
               end
               if (pending) begin
                  cur_half_d  = pend_half_q;
                  pend_half_d = '0;
               end
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any pending ratio and restores the default ratio.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         div_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         cur_half_q  <= CNT_W'(DEFAULT_HALF);
         pend_half_q <= '0;
      end else begin
         state_q     <= state_d;
         div_out_q   <= div_out_d;
         tick_q      <= tick_d;
         cur_half_q  <= cur_half_d;
         pend_half_q <= pend_half_d;
      end
   end

   assign div_out  = div_out_q;
   assign tick     = tick_q;
   assign busy     = (state_q != ST_IDLE);
   assign cur_half = cur_half_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed self-checking bench for div_ratio_ctrl with hand-computed expectations.
module tb_div_ratio_ctrl;

   logic       clk;
   logic       reset;
   logic       en;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_half;
   logic       div_out;
   logic       tick;
   logic       busy;
   logic [7:0] cur_half;

   int vectors;
   int miscompares;

   div_ratio_ctrl #(
      .CNT_W        (8),
      .DEFAULT_HALF (40)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_half  (cfg_half),
      .div_out   (div_out),
      .tick      (tick),
      .busy      (busy),
      .cur_half  (cur_half)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; everything is driven and sampled 1 unit after the rising edge.
   task automatic stepClk();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en_i, input logic valid_i, input logic [7:0] half_i);
      en        = en_i;
      cfg_valid = valid_i;
      cfg_half  = half_i;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One phase of len cycles starting right after an edge: level held, no tick, then toggle with tick.
   task automatic runPhase(input int len, input logic lvl, input string tag);
      for (int i = 1; i < len; i++) begin
         stepClk();
         checkOutput({tag, " hold"}, {30'd0, div_out, tick}, {30'd0, lvl, 1'b0});
      end
      stepClk();
      checkOutput({tag, " edge"}, {30'd0, div_out, tick}, {30'd0, ~lvl, 1'b1});
   endtask

   logic lvl;

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'd0);

      // Reset values
      stepClk();
      stepClk();
      checkOutput("rst div_out", {31'd0, div_out}, 32'd0);
      checkOutput("rst tick", {31'd0, tick}, 32'd0);
      checkOutput("rst busy", {31'd0, busy}, 32'd0);
      checkOutput("rst cur_half", {24'd0, cur_half}, 32'd40);
      checkOutput("rst cfg_ready", {31'd0, cfg_ready}, 32'd0);

      // Test 1: default ratio, period 80, graceful stop from high
      reset = 1'b1;
      #1;
      checkOutput("idle cfg_ready", {31'd0, cfg_ready}, 32'd1);
      applyStimulus(1'b1, 1'b0, 8'd0);
      stepClk();
      checkOutput("t1 start busy", {31'd0, busy}, 32'd1);
      checkOutput("t1 start div_out", {31'd0, div_out}, 32'd0);
      runPhase(40, 1'b0, "t1 p1");
      runPhase(40, 1'b1, "t1 p2");
      runPhase(40, 1'b0, "t1 p3");
      checkOutput("t1 cur_half", {24'd0, cur_half}, 32'd40);
      applyStimulus(1'b0, 1'b0, 8'd0);
      runPhase(40, 1'b1, "t1 stop");
      stepClk();
      checkOutput("t1 idle busy", {31'd0, busy}, 32'd0);
      checkOutput("t1 idle tick", {31'd0, tick}, 32'd0);

      // Test 2: ratio 3 accepted in IDLE, then period 6
      applyStimulus(1'b0, 1'b1, 8'd3);
      #1;
      checkOutput("t2 cfg_ready", {31'd0, cfg_ready}, 32'd1);
      stepClk();
      checkOutput("t2 cur_half", {24'd0, cur_half}, 32'd3);
      checkOutput("t2 still idle", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      stepClk();
      runPhase(3, 1'b0, "t2 p1");
      runPhase(3, 1'b1, "t2 p2");
      runPhase(3, 1'b0, "t2 p3");

      // Switch running ratio from 3 to 40
      applyStimulus(1'b1, 1'b1, 8'd40);
      stepClk();
      checkOutput("t3a ready low", {31'd0, cfg_ready}, 32'd0);
      checkOutput("t3a div_out", {31'd0, div_out}, 32'd1);
      applyStimulus(1'b1, 1'b0, 8'd0);
      runPhase(2, 1'b1, "t3a finish");
      checkOutput("t3a cur_half", {24'd0, cur_half}, 32'd40);
      checkOutput("t3a ready back", {31'd0, cfg_ready}, 32'd1);
      runPhase(40, 1'b0, "t3a p40");

      // Test 3: ratio 10 offered at cnt=5 of a 40 phase
      for (int i = 0; i < 5; i++) begin
         stepClk();
      end
      applyStimulus(1'b1, 1'b1, 8'd10);
      checkOutput("t3 ready pre", {31'd0, cfg_ready}, 32'd1);
      stepClk();
      checkOutput("t3 ready low", {31'd0, cfg_ready}, 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      runPhase(34, 1'b1, "t3 finish40");
      checkOutput("t3 cur_half", {24'd0, cur_half}, 32'd10);
      checkOutput("t3 ready back", {31'd0, cfg_ready}, 32'd1);
      runPhase(10, 1'b0, "t3 p10a");
      runPhase(10, 1'b1, "t3 p10b");

      // Test 4: switch to 8, stop while high at cnt=2
      applyStimulus(1'b1, 1'b1, 8'd8);
      stepClk();
      applyStimulus(1'b1, 1'b0, 8'd0);
      runPhase(9, 1'b0, "t4 finish10");
      checkOutput("t4 cur_half", {24'd0, cur_half}, 32'd8);
      stepClk();
      stepClk();
      applyStimulus(1'b0, 1'b0, 8'd0);
      stepClk();
      checkOutput("t4 stop busy", {31'd0, busy}, 32'd1);
      checkOutput("t4 stop div_out", {31'd0, div_out}, 32'd1);
      runPhase(5, 1'b1, "t4 stop high");
      stepClk();
      checkOutput("t4 idle busy", {31'd0, busy}, 32'd0);
      checkOutput("t4 idle tick", {31'd0, tick}, 32'd0);

      // Test 4b: stop while low at cnt=2, no tick, stays low
      applyStimulus(1'b1, 1'b0, 8'd0);
      stepClk();
      runPhase(8, 1'b0, "t4b p1");
      runPhase(8, 1'b1, "t4b p2");
      stepClk();
      stepClk();
      applyStimulus(1'b0, 1'b0, 8'd0);
      for (int i = 1; i <= 6; i++) begin
         stepClk();
         checkOutput("t4b stop low", {30'd0, div_out, tick}, 32'd0);
         if (i == 5) checkOutput("t4b busy before", {31'd0, busy}, 32'd1);
      end
      checkOutput("t4b busy after", {31'd0, busy}, 32'd0);

      // Test 5: ratio 0 clamps to 1, toggle every clk, stop within 2 clks
      applyStimulus(1'b0, 1'b1, 8'd0);
      stepClk();
      checkOutput("t5 cur_half", {24'd0, cur_half}, 32'd1);
      applyStimulus(1'b1, 1'b0, 8'd0);
      stepClk();
      checkOutput("t5 start", {30'd0, div_out, tick}, 32'd0);
      lvl = 1'b0;
      for (int i = 0; i < 6; i++) begin
         stepClk();
         checkOutput("t5 toggle", {30'd0, div_out, tick}, {30'd0, ~lvl, 1'b1});
         lvl = ~lvl;
      end
      applyStimulus(1'b0, 1'b0, 8'd0);
      stepClk();
      checkOutput("t5 stop1", {30'd0, div_out, tick}, 32'd3);
      stepClk();
      checkOutput("t5 stop2", {30'd0, div_out, tick}, 32'd1);
      checkOutput("t5 stop busy", {31'd0, busy}, 32'd0);
      stepClk();
      checkOutput("t5 settled", {30'd0, div_out, tick}, 32'd0);

      // Test 6: reset in PEND (current 20, pending 12)
      applyStimulus(1'b0, 1'b1, 8'd20);
      stepClk();
      checkOutput("t6 cur_half 20", {24'd0, cur_half}, 32'd20);
      applyStimulus(1'b1, 1'b0, 8'd0);
      stepClk();
      for (int i = 0; i < 3; i++) begin
         stepClk();
      end
      applyStimulus(1'b1, 1'b1, 8'd12);
      stepClk();
      checkOutput("t6 pend ready", {31'd0, cfg_ready}, 32'd0);
      checkOutput("t6 pend cur", {24'd0, cur_half}, 32'd20);
      applyStimulus(1'b1, 1'b0, 8'd0);
      stepClk();
      stepClk();
      reset = 1'b0;
      #1;
      checkOutput("t6 rst ready", {31'd0, cfg_ready}, 32'd0);
      stepClk();
      checkOutput("t6 rst outs", {29'd0, div_out, tick, busy}, 32'd0);
      checkOutput("t6 rst cur_half", {24'd0, cur_half}, 32'd40);
      applyStimulus(1'b0, 1'b0, 8'd0);
      reset = 1'b1;
      stepClk();
      checkOutput("t6 rel busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, 1'b0, 8'd0);
      stepClk();
      runPhase(40, 1'b0, "t6 p1");
      runPhase(40, 1'b1, "t6 p2");
      applyStimulus(1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 40; i++) begin
         stepClk();
      end
      checkOutput("t6 final busy", {31'd0, busy}, 32'd0);
      checkOutput("t6 final cur_half", {24'd0, cur_half}, 32'd40);
      checkOutput("t6 final div_out", {31'd0, div_out}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
